// File: rtl/wfg_stim_ramp.sv
// wfg_stim_ramp: AXI-Stream ramp stimulus generator; counts start..end in steps of inc,
// wrapping back to start and flagging tlast on the final sample of each period.
module wfg_stim_ramp #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int PCNT_WIDTH      = 16
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       ctrl_en_i,
    input  logic [AXIS_DATA_WIDTH-1:0] cfg_start_i,
    input  logic [AXIS_DATA_WIDTH-1:0] cfg_inc_i,
    input  logic [AXIS_DATA_WIDTH-1:0] cfg_end_i,
    input  logic                       wfg_axis_tready_i,
    output logic                       wfg_axis_tvalid_o,
    output logic                       wfg_axis_tlast_o,
    output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
    output logic                       busy_o,
    output logic [PCNT_WIDTH-1:0]      period_cnt_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state_q, state_d;
    logic [AXIS_DATA_WIDTH-1:0] acc_q, acc_d, start_q, start_d, inc_q, inc_d, end_q, end_d;
    logic [PCNT_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [AXIS_DATA_WIDTH:0] nxt;
    logic wrap, hs;
    // The extra carry bit makes an overflowing step count as a wrap, never as a small value.
    assign nxt  = {1'b0, acc_q} + {1'b0, inc_q};
    assign wrap = nxt[AXIS_DATA_WIDTH] | (nxt[AXIS_DATA_WIDTH-1:0] > end_q);
    assign hs   = wfg_axis_tvalid_o & wfg_axis_tready_i;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        start_d = start_q;
        inc_d   = inc_q;
        end_d   = end_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            IDLE: if (ctrl_en_i) begin
                state_d = RUN;
                start_d = cfg_start_i;
                inc_d   = cfg_inc_i;
                end_d   = cfg_end_i;
                acc_d   = cfg_start_i;
                pcnt_d  = '0;
            end
            RUN: begin
                if (hs) begin
                    acc_d  = wrap ? start_q : nxt[AXIS_DATA_WIDTH-1:0];
                    pcnt_d = wrap ? pcnt_q + PCNT_WIDTH'(1) : pcnt_q;
                end
                if (!ctrl_en_i) state_d = hs ? IDLE : DRAIN;
            end
            DRAIN: state_d = hs ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            start_q <= '0;
            inc_q   <= '0;
            end_q   <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            start_q <= start_d;
            inc_q   <= inc_d;
            end_q   <= end_d;
            pcnt_q  <= pcnt_d;
        end
    end
    assign wfg_axis_tvalid_o = state_q != IDLE;
    assign wfg_axis_tlast_o  = wfg_axis_tvalid_o & wrap;
    assign wfg_axis_tdata_o  = acc_q;
    assign busy_o            = wfg_axis_tvalid_o;
    assign period_cnt_o      = pcnt_q;
endmodule

// File: tb/tb_wfg_stim_ramp.sv
// tb_wfg_stim_ramp: directed bench for wfg_stim_ramp with an arithmetic reference model
// checked every cycle, plus literal beat sequences for each scenario.
module tb_wfg_stim_ramp;
    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, tready = 1'b0;
    logic [31:0] cfg_start = '0, cfg_inc = '0, cfg_end = '0;
    logic        tvalid, tlast, busy;
    logic [31:0] tdata;
    logic [15:0] pcnt;
    int total = 0, bad = 0;
    logic [32:0] beats[$];
    logic [32:0] exp_q[$];

    wfg_stim_ramp dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .ctrl_en_i(en),
        .cfg_start_i(cfg_start), .cfg_inc_i(cfg_inc), .cfg_end_i(cfg_end),
        .wfg_axis_tready_i(tready), .wfg_axis_tvalid_o(tvalid), .wfg_axis_tlast_o(tlast),
        .wfg_axis_tdata_o(tdata), .busy_o(busy), .period_cnt_o(pcnt)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 generating, 2 finishing the last offered sample.
    int          m_mode;
    logic [31:0] m_acc, m_start, m_inc, m_end;
    logic [15:0] m_pcnt;
    longint      m_sum;
    logic        m_wrap, m_hs;
    assign m_sum  = longint'(m_acc) + longint'(m_inc);
    assign m_wrap = m_sum > longint'(m_end);
    assign m_hs   = (m_mode != 0) && tready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0; m_acc <= '0; m_pcnt <= '0;
            m_start <= '0; m_inc <= '0; m_end <= '0;
        end else if (m_mode == 0) begin
            if (en) begin
                m_mode <= 1; m_start <= cfg_start; m_inc <= cfg_inc; m_end <= cfg_end;
                m_acc <= cfg_start; m_pcnt <= '0;
            end
        end else if (m_mode == 1) begin
            if (m_hs) begin
                m_acc  <= m_wrap ? m_start : m_sum[31:0];
                m_pcnt <= m_wrap ? m_pcnt + 16'd1 : m_pcnt;
            end
            if (!en) m_mode <= m_hs ? 0 : 2;
        end else if (m_hs) m_mode <= 0;
    end

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        chk("tvalid", 64'(tvalid), 64'(m_mode != 0));
        chk("busy", 64'(busy), 64'(m_mode != 0));
        chk("tlast", 64'(tlast), 64'((m_mode != 0) && m_wrap));
        chk("tdata", 64'(tdata), 64'(m_acc));
        chk("pcnt", 64'(pcnt), 64'(m_pcnt));
        if (tvalid && tready) beats.push_back({tlast, tdata});
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cfg(logic [31:0] s, logic [31:0] i, logic [31:0] e);
        cfg_start = s; cfg_inc = i; cfg_end = e;
        beats.delete();
        exp_q.delete();
    endtask

    function automatic void e(logic l, logic [31:0] d);
        exp_q.push_back({l, d});
    endfunction

    task automatic expect_beats(string n);
        chk({n, "_count"}, 64'(beats.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++)
            chk($sformatf("%s_beat%0d", n, i), 64'(beats[i]), 64'(exp_q[i]));
    endtask

    initial begin
        #1 rst = 1'b1;
        cyc(2);
        chk("rst_tvalid", 64'(tvalid), 0);
        chk("rst_tlast", 64'(tlast), 0);
        chk("rst_tdata", 64'(tdata), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_pcnt", 64'(pcnt), 0);
        rst = 1'b0;
        cyc(1);

        cfg(0, 1, 3); tready = 1'b1; en = 1'b1;
        cyc(10); en = 1'b0; cyc(1);
        for (int i = 0; i < 10; i++) e(i % 4 == 3, 32'(i % 4));
        expect_beats("basic");
        chk("basic_pcnt", 64'(pcnt), 2);
        chk("basic_idle", 64'(tvalid), 0);
        chk("basic_tdata_hold", 64'(tdata), 2);

        cfg(0, 1, 3); en = 1'b1;
        cyc(3); cfg_end = 100; cyc(5); en = 1'b0; cyc(1);
        e(0, 0); e(0, 1); e(0, 2); e(1, 3); e(0, 0); e(0, 1); e(0, 2); e(1, 3);
        expect_beats("cfgfreeze");
        chk("cfgfreeze_pcnt", 64'(pcnt), 2);

        cfg(10, 5, 22); tready = 1'b0; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            tready = ~tready;
        end
        en = 1'b0; tready = 1'b1; cyc(1);
        e(0, 10); e(0, 15); e(1, 20); e(0, 10); e(0, 15); e(1, 20); e(0, 10);
        expect_beats("stall");
        chk("stall_pcnt", 64'(pcnt), 2);
        chk("stall_tdata_hold", 64'(tdata), 15);

        cfg(32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFFF); en = 1'b1;
        cyc(2); en = 1'b0; cyc(1);
        e(1, 32'hFFFF_FFF0); e(1, 32'hFFFF_FFF0);
        expect_beats("carry");
        chk("carry_pcnt", 64'(pcnt), 2);

        cfg(7, 0, 9); en = 1'b1;
        cyc(4); en = 1'b0; cyc(1);
        repeat (4) e(0, 7);
        expect_beats("inc0");
        chk("inc0_pcnt", 64'(pcnt), 0);

        cfg(5, 1, 2); en = 1'b1;
        cyc(4); en = 1'b0; cyc(1);
        repeat (4) e(1, 5);
        expect_beats("startgtend");
        chk("startgtend_pcnt", 64'(pcnt), 4);

        cfg(0, 1, 3); en = 1'b1;
        cyc(3); tready = 1'b0; en = 1'b0; cyc(3);
        chk("drain_busy", 64'(busy), 1);
        chk("drain_tvalid", 64'(tvalid), 1);
        chk("drain_tdata", 64'(tdata), 2);
        tready = 1'b1; cyc(1);
        chk("drain_done_tvalid", 64'(tvalid), 0);
        chk("drain_done_busy", 64'(busy), 0);
        chk("drain_done_tdata", 64'(tdata), 2);
        e(0, 0); e(0, 1); e(0, 2);
        expect_beats("drain");

        cfg(0, 1, 3); en = 1'b1;
        cyc(6);
        chk("prerst_pcnt", 64'(pcnt), 1);
        chk("prerst_tdata", 64'(tdata), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_tvalid", 64'(tvalid), 0);
        chk("arst_pcnt", 64'(pcnt), 0);
        chk("arst_tdata", 64'(tdata), 0);
        chk("arst_busy", 64'(busy), 0);
        rst = 1'b0; en = 1'b0;
        cyc(2);
        chk("postrst_idle", 64'(tvalid), 0);
        en = 1'b1; cyc(2);
        chk("restart_tvalid", 64'(tvalid), 1);
        chk("restart_tdata", 64'(tdata), 1);
        en = 1'b0; cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
